// File: rtl/mem_access_master_if.sv
// Request/response and memory-system signals of the load/store sequencer.
// master is the sequencer's view; slave is the CPU + memory-system view.
interface mem_access_master_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic        req_write_i;
  logic [1:0]  req_size_i;
  logic        req_unsigned_i;
  logic [31:0] req_addr_i;
  logic [31:0] req_wdata_i;
  logic        rsp_valid_o;
  logic [31:0] rsp_rdata_o;
  logic        rsp_error_o;
  logic        mem_write_enable_o;
  logic [31:0] mem_write_data_o;
  logic [31:0] mem_address_o;
  logic [31:0] mem_read_data_i;

  modport master (
    input  req_valid_i, req_write_i, req_size_i, req_unsigned_i,
           req_addr_i, req_wdata_i, mem_read_data_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
           mem_write_enable_o, mem_write_data_o, mem_address_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_size_i, req_unsigned_i,
           req_addr_i, req_wdata_i, mem_read_data_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_error_o,
           mem_write_enable_o, mem_write_data_o, mem_address_o
  );
endinterface

// File: rtl/mem_access_master.sv
// Load/store sequencer: one request at a time, alignment and map checks,
// sub-word stores as read-modify-write, extended load data in a 1-cycle response.
module mem_access_master #(
  parameter logic [31:0] ROM_BASE  = 32'h0040_0000,
  parameter logic [31:0] RAM_BASE  = 32'h1001_0000,
  parameter int unsigned ROM_DEPTH = 64,
  parameter int unsigned RAM_DEPTH = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  mem_access_master_if.master     bus,
  output logic [2:0]              dbg_state
);

  // Handshake: a request is taken on a rising clk edge where req_valid_i and
  // req_ready_o are both 1; req_ready_o is 1 only in IDLE, and rsp_valid_o
  // is a single-cycle pulse with no back-pressure from the requester.

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    RMW_READ = 3'd2,
    WRITE    = 3'd3,
    RESP     = 3'd4
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BAD  = 2'b11;

  // 33-bit bounds so a region ending at 2^32 cannot wrap to zero.
  localparam logic [32:0] ROM_LO = {1'b0, ROM_BASE};
  localparam logic [32:0] ROM_HI = ROM_LO + (33'(ROM_DEPTH) << 2);
  localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
  localparam logic [32:0] RAM_HI = RAM_LO + (33'(RAM_DEPTH) << 2);

  state_t      state;
  state_t      state_next;

  logic        ready_c;
  logic        rsp_valid_c;
  logic        write_enable_c;

  logic [32:0] addr_ext;
  logic        in_rom;
  logic        in_ram;
  logic        req_error;

  logic [31:0] addr_q;
  logic [1:0]  lane_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] wdata_q;
  logic [31:0] wr_word_q;
  logic [31:0] rdata_q;
  logic        error_q;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane,
                                              input logic        uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: return uns ? {24'd0, b} : {{24{b[7]}}, b};
      SZ_HALF: return uns ? {16'd0, h} : {{16{h[15]}}, h};
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] merge_lane(input logic [31:0] old,
                                             input logic [31:0] wd,
                                             input logic [1:0]  size,
                                             input logic [1:0]  lane);
    logic [31:0] m;
    m = old;
    if (size == SZ_BYTE) m[{lane, 3'b000} +: 8] = wd[7:0];
    else                 m[{lane[1], 4'b0000} +: 16] = wd[15:0];
    return m;
  endfunction

  always_comb begin
    addr_ext  = {1'b0, bus.req_addr_i};
    in_rom    = (addr_ext >= ROM_LO) && (addr_ext < ROM_HI);
    in_ram    = (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);
    req_error = (bus.req_size_i == SZ_BAD)
             || ((bus.req_size_i == SZ_HALF) && bus.req_addr_i[0])
             || ((bus.req_size_i == SZ_WORD) && (bus.req_addr_i[1:0] != 2'b00))
             || (!in_rom && !in_ram)
             || (bus.req_write_i && in_rom);
  end

  // State register: async reset aborts any transaction, dropping WE at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next     = state;
    ready_c        = 1'b0;
    rsp_valid_c    = 1'b0;
    write_enable_c = 1'b0;
    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (bus.req_valid_i) begin
          if (req_error)                     state_next = RESP;
          else if (!bus.req_write_i)         state_next = READ;
          else if (bus.req_size_i == SZ_WORD) state_next = WRITE;
          else                               state_next = RMW_READ;
        end
      end
      READ:     state_next = RESP;
      RMW_READ: state_next = WRITE;
      WRITE: begin
        write_enable_c = 1'b1;
        state_next     = RESP;
      end
      RESP: begin
        rsp_valid_c = 1'b1;
        state_next  = IDLE;
      end
      default:  state_next = IDLE;
    endcase
  end

  // Datapath; response fields are only rewritten on the edge entering RESP,
  // so they hold between responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q    <= '0;
      lane_q    <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      wdata_q   <= '0;
      wr_word_q <= '0;
      rdata_q   <= '0;
      error_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid_i) begin
            addr_q  <= {bus.req_addr_i[31:2], 2'b00};
            lane_q  <= bus.req_addr_i[1:0];
            size_q  <= bus.req_size_i;
            uns_q   <= bus.req_unsigned_i;
            wdata_q <= bus.req_wdata_i;
            if (req_error) begin
              rdata_q <= '0;
              error_q <= 1'b1;
            end else if (bus.req_write_i && (bus.req_size_i == SZ_WORD)) begin
              wr_word_q <= bus.req_wdata_i;
            end
          end
        end
        READ: begin
          rdata_q <= load_extend(bus.mem_read_data_i, size_q, lane_q, uns_q);
          error_q <= 1'b0;
        end
        RMW_READ: wr_word_q <= merge_lane(bus.mem_read_data_i, wdata_q, size_q, lane_q);
        WRITE: begin
          rdata_q <= '0;
          error_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready_o        = ready_c;
  assign bus.rsp_valid_o        = rsp_valid_c;
  assign bus.rsp_rdata_o        = rdata_q;
  assign bus.rsp_error_o        = error_q;
  assign bus.mem_write_enable_o = write_enable_c;
  assign bus.mem_write_data_o   = wr_word_q;
  assign bus.mem_address_o      = addr_q;
  assign dbg_state              = state;

endmodule

// File: tb/tb_mem_access_master.sv
// Bench for mem_access_master: directed vector table, randomized traffic
// against an arithmetic reference model, and a reset-abort sequence.
module tb_mem_access_master;
  localparam logic [31:0] ROM_BASE = 32'h0040_0000;
  localparam logic [31:0] RAM_BASE = 32'h1001_0000;
  localparam int          DEPTH    = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mem_access_master_if bus();
  logic [2:0] dbg_state;

  mem_access_master #(
    .ROM_BASE(ROM_BASE), .RAM_BASE(RAM_BASE), .ROM_DEPTH(DEPTH), .RAM_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .dbg_state(dbg_state)
  );

  int vectors = 0;
  int miscompares = 0;

  // ---------------- memory environment ----------------
  function automatic logic [31:0] rom_word(input int i);
    if (i == 0)  return 32'h8765_4321;
    if (i == 63) return 32'hCAFE_F00D;
    return 32'h9E37_79B9 * 32'(i + 1);
  endfunction

  function automatic logic [31:0] ram_init(input int i);
    return (i == 2) ? 32'h1122_3344 : 32'h0;
  endfunction

  logic [31:0] ram_mem [DEPTH];
  logic        mem_init;
  logic [31:0] mem_rd;
  int          we_total = 0;

  always_comb begin
    mem_rd = 32'hBAAD_F00D;
    if (bus.mem_address_o >= ROM_BASE && bus.mem_address_o < ROM_BASE + 32'd256)
      mem_rd = rom_word(int'(bus.mem_address_o[7:2]));
    else if (bus.mem_address_o >= RAM_BASE && bus.mem_address_o < RAM_BASE + 32'd256)
      mem_rd = ram_mem[bus.mem_address_o[7:2]];
  end
  assign bus.mem_read_data_i = mem_rd;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < DEPTH; i++) ram_mem[i] <= ram_init(i);
    end else if (bus.mem_write_enable_o &&
                 bus.mem_address_o >= RAM_BASE && bus.mem_address_o < RAM_BASE + 32'd256) begin
      ram_mem[bus.mem_address_o[7:2]] <= bus.mem_write_data_o;
    end
  end

  always @(negedge clk) if (bus.mem_write_enable_o) we_total++;

  // ---------------- reference model ----------------
  logic [31:0] model_ram [DEPTH];
  int          model_stores = 0;

  task automatic model_step(input logic w, input logic [1:0] sz, input logic uns,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic err, output logic [31:0] rd, output int lat,
                            output logic we_exp, output logic [31:0] wexp);
    longint unsigned la;
    logic in_rom, in_ram;
    int idx, sh;
    logic [31:0] word, v, mask;
    la     = a;
    in_rom = la >= ROM_BASE && la < ROM_BASE + 4 * DEPTH;
    in_ram = la >= RAM_BASE && la < RAM_BASE + 4 * DEPTH;
    err = (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0)
       || !(in_rom || in_ram) || (w && in_rom);
    rd = 0; we_exp = 0; wexp = 0; lat = 1;
    if (!err) begin
      idx  = in_rom ? int'((la - ROM_BASE) / 4) : int'((la - RAM_BASE) / 4);
      word = in_rom ? rom_word(idx) : model_ram[idx];
      sh   = int'(a % 4) * 8;
      if (!w) begin
        lat = 2;
        if (sz == 0) begin
          v  = (word >> sh) & 32'hFF;
          rd = (!uns && v >= 128) ? v + 32'hFFFF_FF00 : v;
        end else if (sz == 1) begin
          v  = (word >> sh) & 32'hFFFF;
          rd = (!uns && v >= 32768) ? v + 32'hFFFF_0000 : v;
        end else rd = word;
      end else begin
        we_exp = 1;
        model_stores++;
        if (sz == 2) begin
          lat  = 2;
          wexp = wd;
        end else begin
          lat  = 3;
          mask = ((sz == 0) ? 32'hFF : 32'hFFFF) << sh;
          wexp = (word & ~mask) | ((wd << sh) & mask);
        end
        model_ram[idx] = wexp;
      end
    end
  endtask

  // ---------------- driver / checker ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic do_req(input logic w, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic [31:0] rd, output logic er,
                        output int we_cnt, output int we_cyc,
                        output logic [31:0] we_addr, output logic [31:0] we_data,
                        output logic rdy_at_rsp);
    lat = 0; rd = '0; er = 1'b0; we_cnt = 0; we_cyc = 0;
    we_addr = '0; we_data = '0; rdy_at_rsp = 1'b1;
    for (int i = 0; i < 10 && !bus.req_ready_o; i++) @(negedge clk);
    bus.req_valid_i    = 1'b1;
    bus.req_write_i    = w;
    bus.req_size_i     = sz;
    bus.req_unsigned_i = uns;
    bus.req_addr_i     = a;
    bus.req_wdata_i    = wd;
    @(posedge clk);
    #1 bus.req_valid_i = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      if (bus.mem_write_enable_o) begin
        we_cnt++;
        we_cyc  = cyc;
        we_addr = bus.mem_address_o;
        we_data = bus.mem_write_data_o;
      end
      if (bus.rsp_valid_o) begin
        lat        = cyc;
        rd         = bus.rsp_rdata_o;
        er         = bus.rsp_error_o;
        rdy_at_rsp = bus.req_ready_o;
        break;
      end
    end
  endtask

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] a;
    logic [31:0] wd;
    logic        exp_err;
    logic [31:0] exp_rd;
    int          exp_lat;
    logic        exp_we;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t        vecs [21];
  logic [37:0] exp_q [$];
  logic [31:0] exp_wq [$];

  // ---------------- test ----------------
  initial begin
    int lat, we_cnt, we_cyc;
    logic [31:0] rd, we_addr, we_data;
    logic er, rdy;
    logic m_err, m_we;
    logic [31:0] m_rd, m_wd;
    int m_lat;

    //        w  sz     uns a              wd             err rd             lat we wdata
    vecs[0]  = '{1, 2'd2, 0, 32'h1001_0004, 32'hDEAD_BEEF, 0, 32'h0,         2, 1, 32'hDEAD_BEEF};
    vecs[1]  = '{0, 2'd2, 0, 32'h1001_0004, 32'h0,         0, 32'hDEAD_BEEF, 2, 0, 32'h0};
    vecs[2]  = '{1, 2'd0, 0, 32'h1001_000A, 32'h5566_77AA, 0, 32'h0,         3, 1, 32'h11AA_3344};
    vecs[3]  = '{0, 2'd0, 0, 32'h1001_000A, 32'h0,         0, 32'hFFFF_FFAA, 2, 0, 32'h0};
    vecs[4]  = '{0, 2'd0, 1, 32'h1001_000A, 32'h0,         0, 32'h0000_00AA, 2, 0, 32'h0};
    vecs[5]  = '{0, 2'd1, 0, 32'h1001_0008, 32'h0,         0, 32'h0000_3344, 2, 0, 32'h0};
    vecs[6]  = '{0, 2'd1, 0, 32'h1001_000A, 32'h0,         0, 32'h0000_11AA, 2, 0, 32'h0};
    vecs[7]  = '{0, 2'd2, 0, 32'h1001_0002, 32'h0,         1, 32'h0,         1, 0, 32'h0};
    vecs[8]  = '{1, 2'd2, 0, 32'h0040_0000, 32'h1234_5678, 1, 32'h0,         1, 0, 32'h0};
    vecs[9]  = '{0, 2'd2, 0, 32'h0000_0000, 32'h0,         1, 32'h0,         1, 0, 32'h0};
    vecs[10] = '{0, 2'd3, 0, 32'h1001_0000, 32'h0,         1, 32'h0,         1, 0, 32'h0};
    vecs[11] = '{0, 2'd1, 0, 32'h0040_0002, 32'h0,         0, 32'hFFFF_8765, 2, 0, 32'h0};
    vecs[12] = '{0, 2'd2, 0, 32'h0040_00FC, 32'h0,         0, 32'hCAFE_F00D, 2, 0, 32'h0};
    vecs[13] = '{0, 2'd2, 0, 32'h0040_0100, 32'h0,         1, 32'h0,         1, 0, 32'h0};
    vecs[14] = '{1, 2'd1, 0, 32'h1001_00FE, 32'h0000_BEEF, 0, 32'h0,         3, 1, 32'hBEEF_0000};
    vecs[15] = '{0, 2'd1, 1, 32'h1001_00FE, 32'h0,         0, 32'h0000_BEEF, 2, 0, 32'h0};
    vecs[16] = '{1, 2'd2, 0, 32'h1001_0100, 32'h0,         1, 32'h0,         1, 0, 32'h0};
    vecs[17] = '{0, 2'd2, 0, 32'hFFFF_FFFC, 32'h0,         1, 32'h0,         1, 0, 32'h0};
    vecs[18] = '{0, 2'd0, 0, 32'h1001_0005, 32'h0,         0, 32'hFFFF_FFBE, 2, 0, 32'h0};
    vecs[19] = '{1, 2'd1, 0, 32'h1001_0001, 32'h0,         1, 32'h0,         1, 0, 32'h0};
    vecs[20] = '{1, 2'd0, 0, 32'h0040_0003, 32'h0,         1, 32'h0,         1, 0, 32'h0};

    bus.req_valid_i = 1'b0; bus.req_write_i = 1'b0; bus.req_size_i = 2'd0;
    bus.req_unsigned_i = 1'b0; bus.req_addr_i = '0; bus.req_wdata_i = '0;
    mem_init = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_ram[i] = ram_init(i);

    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    mem_init = 1'b0;
    check("rst_ready", 32'(bus.req_ready_o), 32'd1);
    check("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    check("rst_rdata", bus.rsp_rdata_o, 32'd0);
    check("rst_error", 32'(bus.rsp_error_o), 32'd0);
    check("rst_we", 32'(bus.mem_write_enable_o), 32'd0);
    check("rst_wdata", bus.mem_write_data_o, 32'd0);
    check("rst_addr", bus.mem_address_o, 32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_ready", 32'(bus.req_ready_o), 32'd1);
    check("idle_we_total", 32'(we_total), 32'd0);

    // directed vector table
    foreach (vecs[i]) begin
      model_step(vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd,
                 m_err, m_rd, m_lat, m_we, m_wd);
      do_req(vecs[i].w, vecs[i].sz, vecs[i].uns, vecs[i].a, vecs[i].wd,
             lat, rd, er, we_cnt, we_cyc, we_addr, we_data, rdy);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      check($sformatf("vec%0d_error", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_we_count", i), 32'(we_cnt), 32'(vecs[i].exp_we));
      check($sformatf("vec%0d_ready_in_resp", i), 32'(rdy), 32'd0);
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d_wdata", i), we_data, vecs[i].exp_wdata);
        check($sformatf("vec%0d_waddr", i), we_addr, vecs[i].a & 32'hFFFF_FFFC);
        check($sformatf("vec%0d_we_cycle", i), 32'(we_cyc), 32'(vecs[i].exp_lat - 1));
      end
    end

    // randomized traffic against the model
    for (int n = 0; n < 300; n++) begin
      logic w, uns;
      logic [1:0] sz;
      logic [31:0] a, wd;
      logic [37:0] e;
      int r;
      w   = 1'($urandom_range(0, 1));
      sz  = 2'($urandom_range(0, 3));
      uns = 1'($urandom_range(0, 1));
      wd  = $urandom;
      r   = $urandom_range(0, 9);
      if (r <= 5)      a = RAM_BASE + 32'($urandom_range(0, 4 * DEPTH + 7));
      else if (r <= 7) a = ROM_BASE + 32'($urandom_range(0, 4 * DEPTH + 7));
      else if (r == 8) a = $urandom;
      else             a = RAM_BASE - 32'($urandom_range(1, 4));
      model_step(w, sz, uns, a, wd, m_err, m_rd, m_lat, m_we, m_wd);
      exp_q.push_back({m_we, 4'(m_lat), m_err, m_rd});
      exp_wq.push_back(m_wd);
      do_req(w, sz, uns, a, wd, lat, rd, er, we_cnt, we_cyc, we_addr, we_data, rdy);
      e = exp_q.pop_front();
      m_wd = exp_wq.pop_front();
      check("rnd_latency", 32'(lat), 32'(e[36:33]));
      check("rnd_error", 32'(er), 32'(e[32]));
      check("rnd_rdata", rd, e[31:0]);
      check("rnd_we_count", 32'(we_cnt), 32'(e[37]));
      if (e[37]) check("rnd_wdata", we_data, m_wd);
    end

    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) check($sformatf("ram_word%0d", i), ram_mem[i], model_ram[i]);
    check("we_total_vs_stores", 32'(we_total), 32'(model_stores));

    // reset asserted during RMW_READ of a byte store
    begin
      int we_before;
      we_before = we_total;
      for (int i = 0; i < 10 && !bus.req_ready_o; i++) @(negedge clk);
      bus.req_valid_i = 1'b1; bus.req_write_i = 1'b1; bus.req_size_i = 2'd0;
      bus.req_unsigned_i = 1'b0; bus.req_addr_i = 32'h1001_000A; bus.req_wdata_i = 32'h77;
      @(posedge clk);
      #1 bus.req_valid_i = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_we_async", 32'(bus.mem_write_enable_o), 32'd0);
      check("abort_ready_async", 32'(bus.req_ready_o), 32'd1);
      for (int c = 0; c < 2; c++) begin
        @(negedge clk);
        check("abort_rsp_in_reset", 32'(bus.rsp_valid_o), 32'd0);
      end
      reset = 1'b1;
      for (int c = 0; c < 3; c++) begin
        @(negedge clk);
        check("abort_rsp_after", 32'(bus.rsp_valid_o), 32'd0);
      end
      #1;
      check("abort_we_total", 32'(we_total), 32'(we_before));
      check("abort_ram_unchanged", ram_mem[2], model_ram[2]);
      check("abort_ready", 32'(bus.req_ready_o), 32'd1);
      check("abort_rdata_cleared", bus.rsp_rdata_o, 32'd0);
      do_req(1'b0, 2'd2, 1'b0, 32'h1001_0008, 32'h0,
             lat, rd, er, we_cnt, we_cyc, we_addr, we_data, rdy);
      check("abort_reload_latency", 32'(lat), 32'd2);
      check("abort_reload_rdata", rd, model_ram[2]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // global time limit so the run always ends
  initial begin
    #400000;
    $display("FAIL timeout: simulation did not complete, expected finish before 400000");
    $fatal(1, "timeout");
  end
endmodule
